// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester write-back arbiter onto the regfile write port
//
// regfile_wb_fifo: per-requester write queue.
//   clk, reset              clock, async active-high reset
//   push, pop               enqueue request (gated by ready), dequeue request (gated by nonempty)
//   in_sel/in_data/in_width entry being pushed
//   ready, nonempty         registered-count status
//   head_sel/data/width     oldest entry
//   sel_mask                one-hot OR of sel over every occupied entry
//
// regfile_wb_arbiter: top.
//   clk, reset                            clock, async active-high reset
//   a_valid/a_ready/a_sel/a_data/a_width  requester A (ALU) write-back handshake
//   b_valid/b_ready/b_sel/b_data/b_width  requester B (load/store) write-back handshake
//   wr/wrsel/din/width                    registered regfile write port
//   pending                               registers with a queued or presented write
//   grant_b                               last grant went to B

module regfile_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [3:0]    in_sel,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_width,
    output logic          ready,
    output logic          nonempty,
    output logic [3:0]    head_sel,
    output logic [DW-1:0] head_data,
    output logic [1:0]    head_width,
    output logic [15:0]   sel_mask
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [3:0]    sel_mem   [DEPTH];
    logic [DW-1:0] data_mem  [DEPTH];
    logic [1:0]    width_mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] offs;

    // Ready depends only on the registered count, so a full queue stays
    // not-ready even when its head is popped this same cycle.
    assign ready    = (count < CW'(DEPTH));
    assign nonempty = (count != '0);
    assign do_push  = push & ready;
    assign do_pop   = pop & nonempty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            sel_mem[wptr]   <= in_sel;
            data_mem[wptr]  <= in_data;
            width_mem[wptr] <= in_width;
        end
    end

    assign head_sel   = sel_mem[rptr];
    assign head_data  = data_mem[rptr];
    assign head_width = width_mem[rptr];

    // An entry is live when its distance from the read pointer (mod DEPTH,
    // which the pointer width provides for free) is below the count.
    always_comb begin
        sel_mask = '0;
        offs     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = AW'(i) - rptr;
            if ({1'b0, offs} < count) begin
                sel_mask[sel_mem[i]] = 1'b1;
            end
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [3:0]    a_sel,
    input  logic [DW-1:0] a_data,
    input  logic [1:0]    a_width,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [3:0]    b_sel,
    input  logic [DW-1:0] b_data,
    input  logic [1:0]    b_width,
    output logic          wr,
    output logic [3:0]    wrsel,
    output logic [DW-1:0] din,
    output logic [1:0]    width,
    output logic [15:0]   pending,
    output logic          grant_b
);
    logic          a_ne;
    logic          b_ne;
    logic [3:0]    a_hsel;
    logic [3:0]    b_hsel;
    logic [DW-1:0] a_hdata;
    logic [DW-1:0] b_hdata;
    logic [1:0]    a_hwidth;
    logic [1:0]    b_hwidth;
    logic [15:0]   a_mask;
    logic [15:0]   b_mask;
    logic          pick_a;
    logic          pick_b;

    regfile_wb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo_a (
        .clk        (clk),
        .reset      (reset),
        .push       (a_valid),
        .pop        (pick_a),
        .in_sel     (a_sel),
        .in_data    (a_data),
        .in_width   (a_width),
        .ready      (a_ready),
        .nonempty   (a_ne),
        .head_sel   (a_hsel),
        .head_data  (a_hdata),
        .head_width (a_hwidth),
        .sel_mask   (a_mask)
    );

    regfile_wb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo_b (
        .clk        (clk),
        .reset      (reset),
        .push       (b_valid),
        .pop        (pick_b),
        .in_sel     (b_sel),
        .in_data    (b_data),
        .in_width   (b_width),
        .ready      (b_ready),
        .nonempty   (b_ne),
        .head_sel   (b_hsel),
        .head_data  (b_hdata),
        .head_width (b_hwidth),
        .sel_mask   (b_mask)
    );

    // Round robin on pre-push FIFO state: on contention the requester that
    // did not win last time goes first.
    always_comb begin
        pick_a = a_ne & (~b_ne | grant_b);
        pick_b = b_ne & (~a_ne | ~grant_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr      <= 1'b0;
            wrsel   <= '0;
            din     <= '0;
            width   <= '0;
            grant_b <= 1'b0;
        end else begin
            wr <= pick_a | pick_b;
            if (pick_a) begin
                wrsel   <= a_hsel;
                din     <= a_hdata;
                width   <= a_hwidth;
                grant_b <= 1'b0;
            end else if (pick_b) begin
                wrsel   <= b_hsel;
                din     <= b_hdata;
                width   <= b_hwidth;
                grant_b <= 1'b1;
            end
        end
    end

    // The presented write keeps its bit set for the cycle it is on the port.
    assign pending = a_mask | b_mask | (wr ? (16'd1 << wrsel) : 16'd0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int DW    = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [3:0]    a_sel = '0;
    logic [DW-1:0] a_data = '0;
    logic [1:0]    a_width = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [3:0]    b_sel = '0;
    logic [DW-1:0] b_data = '0;
    logic [1:0]    b_width = '0;
    logic          wr;
    logic [3:0]    wrsel;
    logic [DW-1:0] din;
    logic [1:0]    width;
    logic [15:0]   pending;
    logic          grant_b;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_sel   (a_sel),
        .a_data  (a_data),
        .a_width (a_width),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_sel   (b_sel),
        .b_data  (b_data),
        .b_width (b_width),
        .wr      (wr),
        .wrsel   (wrsel),
        .din     (din),
        .width   (width),
        .pending (pending),
        .grant_b (grant_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]    sel;
        logic [DW-1:0] data;
        logic [1:0]    w;
    } ent_t;

    ent_t          qa[$];
    ent_t          qb[$];
    logic          m_wr = 1'b0;
    logic          m_gb = 1'b0;
    logic [3:0]    m_sel = '0;
    logic [DW-1:0] m_din = '0;
    logic [1:0]    m_w = '0;
    int            seen [logic [DW-1:0]];

    function automatic logic [15:0] exp_pending();
        logic [15:0] m;
        m = '0;
        foreach (qa[i]) m[qa[i].sel] = 1'b1;
        foreach (qb[i]) m[qb[i].sel] = 1'b1;
        if (m_wr) m[m_sel] = 1'b1;
        return m;
    endfunction

    // Queue-level model: pushes judged on pre-edge occupancy, one grant per edge.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                qa.delete();
                qb.delete();
                m_wr = 1'b0; m_gb = 1'b0; m_sel = '0; m_din = '0; m_w = '0;
            end else begin
                ent_t e;
                bit   pa;
                bit   pb;
                pa = a_valid && (qa.size() < DEPTH);
                pb = b_valid && (qb.size() < DEPTH);
                m_wr = 1'b0;
                if (qa.size() > 0 && (qb.size() == 0 || m_gb)) begin
                    e = qa.pop_front();
                    m_wr = 1'b1; m_gb = 1'b0;
                    m_sel = e.sel; m_din = e.data; m_w = e.w;
                end else if (qb.size() > 0) begin
                    e = qb.pop_front();
                    m_wr = 1'b1; m_gb = 1'b1;
                    m_sel = e.sel; m_din = e.data; m_w = e.w;
                end
                if (pa) qa.push_back('{sel: a_sel, data: a_data, w: a_width});
                if (pb) qb.push_back('{sel: b_sel, data: b_data, w: b_width});
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("wr", wr, m_wr);
                chk("wrsel", wrsel, m_sel);
                chk("din", din, m_din);
                chk("width", width, m_w);
                chk("grant_b", grant_b, m_gb);
                chk("pending", pending, exp_pending());
                chk("a_ready", a_ready, qa.size() < DEPTH);
                chk("b_ready", b_ready, qb.size() < DEPTH);
                if (wr === 1'b1) begin
                    if (seen.exists(din)) seen[din] = seen[din] + 1;
                    else seen[din] = 1;
                end
            end
        end
    end

    logic [DW-1:0] accepted[$];
    logic [3:0]    cont_exp [4];
    int            bcnt;
    int            acnt;
    bit            saw_full;

    initial begin
        cont_exp[0] = 4'd5; cont_exp[1] = 4'd1; cont_exp[2] = 4'd6; cont_exp[3] = 4'd2;

        // Reset then idle
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wr", wr, 0);
        chk("rst_pending", pending, 16'h0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_wrsel", wrsel, 0);
        chk("rst_din", din, 0);

        // Single write
        a_valid = 1'b1; a_sel = 4'h3; a_data = 64'hFFFF_FFFF_FFFF_FFFF; a_width = 2'h3;
        @(negedge clk);
        a_valid = 1'b0;
        chk("single_pend_n", pending, 16'h0008);
        chk("single_wr_n", wr, 0);
        @(negedge clk);
        chk("single_wr", wr, 1);
        chk("single_wrsel", wrsel, 4'h3);
        chk("single_din", din, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("single_width", width, 2'h3);
        @(negedge clk);
        chk("single_wr_off", wr, 0);
        chk("single_pend_off", pending, 16'h0);

        // Contention: A regs 1,2 and B regs 5,6 back to back
        chk("cont_gb0", grant_b, 0);
        a_valid = 1'b1; a_sel = 4'd1; a_data = 64'h11; a_width = 2'd0;
        b_valid = 1'b1; b_sel = 4'd5; b_data = 64'h55; b_width = 2'd1;
        @(negedge clk);
        a_sel = 4'd2; a_data = 64'h22;
        b_sel = 4'd6; b_data = 64'h66;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cont_wr%0d", k), wr, 1);
            chk($sformatf("cont_sel%0d", k), wrsel, cont_exp[k]);
            @(negedge clk);
        end
        chk("cont_idle", wr, 0);

        // Full FIFO: both streaming, B must stall without loss or duplication
        bcnt = 0; acnt = 0; saw_full = 0;
        for (int k = 0; k < 8; k++) begin
            a_valid = 1'b1; a_sel = 4'(k); a_data = 64'hA0A0_0000_0000_0000 + 64'(acnt);
            b_valid = 1'b1; b_sel = 4'(8 + (bcnt % 8)); b_data = 64'hB0B0_0000_0000_0000 + 64'(bcnt);
            if (b_ready) begin
                accepted.push_back(b_data);
                bcnt++;
            end else begin
                saw_full = 1;
            end
            if (a_ready) acnt++;
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("full_b_stalled", saw_full, 1);
        repeat (8) @(negedge clk);
        chk("full_drained", pending, 16'h0);
        foreach (accepted[i]) begin
            chk($sformatf("full_b_once%0d", i), seen.exists(accepted[i]) ? seen[accepted[i]] : 0, 1);
        end

        // Reset mid-operation
        for (int k = 0; k < 6; k++) begin
            a_valid = 1'b1; a_sel = 4'(k); a_data = 64'hC0 + 64'(k);
            b_valid = 1'b1; b_sel = 4'(15 - k); b_data = 64'hD0 + 64'(k);
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("mid_busy", pending != 16'h0, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_wr", wr, 0);
        chk("mid_pending", pending, 16'h0);
        chk("mid_a_ready", a_ready, 1);
        chk("mid_b_ready", b_ready, 1);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mid_nostale%0d", k), wr, 0);
        end

        // Pending overlap: r4 queued twice
        a_valid = 1'b1; a_sel = 4'd4; a_data = 64'h41; a_width = 2'd2;
        @(negedge clk);
        a_data = 64'h42;
        chk("ovl_p0", pending[4], 1);
        @(negedge clk);
        a_valid = 1'b0;
        chk("ovl_p1", pending[4], 1);
        chk("ovl_d1", din, 64'h41);
        @(negedge clk);
        chk("ovl_p2", pending[4], 1);
        chk("ovl_d2", din, 64'h42);
        chk("ovl_wr2", wr, 1);
        @(negedge clk);
        chk("ovl_p3", pending[4], 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
